fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert handled upstream.
REQ-004 i_run  in  1  fetch enable; 0 = stop issuing new requests.
REQ-005 o_mem_req  out  1  fetch request to instruction memory.
REQ-006 o_mem_addr  out  32  fetch address, word-aligned, valid while o_mem_req=1.
REQ-007 i_mem_ack  in  1  memory accepted request this cycle.
REQ-008 i_mem_rvalid  in  1  read data valid this cycle.
REQ-009 i_mem_rdata  in  32  fetched instruction word.
REQ-010 i_stall  in  1  downstream cannot accept an instruction this cycle.
REQ-011 i_redirect  in  1  branch/jump redirect strobe.
REQ-012 i_redirect_pc  in  32  redirect target.
REQ-013 o_instruction  out  32  instruction to decode stage (drives decode i_instruction).
REQ-014 o_dec_en  out  1  one-cycle strobe, drives decode clk_en.
REQ-015 o_pc  out  32  address of o_instruction.

Function
REQ-016 State machine SHALL have states IDLE, REQ, WAIT, HOLD; exactly one outstanding memory request at any time.
REQ-017 IDLE: o_mem_req=0; i_run=1 -> REQ next cycle, o_mem_addr loaded with pc; i_mem_rvalid ignored.
REQ-018 REQ: o_mem_req=1, o_mem_addr held stable until i_mem_ack=1; ack -> WAIT.
REQ-019 WAIT: on i_mem_rvalid with drop flag clear and i_stall=0 -> o_instruction<=rdata, o_pc<=pc, o_dec_en=1 next cycle, pc<=pc+4, next state REQ if i_run else IDLE.
REQ-020 WAIT: on i_mem_rvalid with i_stall=1 -> capture rdata into o_instruction/o_pc, o_dec_en=0, go HOLD.
REQ-021 HOLD: o_instruction/o_pc stable; first cycle with i_stall=0 -> o_dec_en=1 next cycle, pc<=pc+4, go REQ (i_run=1) or IDLE.
REQ-022 o_dec_en SHALL be high for exactly one cycle per delivered instruction and never for a dropped response.
REQ-023 Latency: rvalid cycle (no stall) -> o_dec_en high on following cycle; ack-to-rvalid latency unbounded, WAIT holds indefinitely.
REQ-024 pc arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-025 Redirect (any state): pc<=i_redirect_pc with bits [1:0] forced to 0, effective next cycle.
REQ-026 Redirect in REQ without ack: address not changed; drop flag set; response to that request discarded, then REQ with new pc.
REQ-027 Redirect in REQ with ack same cycle, or in WAIT: drop flag set; matching rvalid discarded, drop cleared, go REQ.
REQ-028 Redirect same cycle as rvalid in WAIT: redirect wins; data discarded, no o_dec_en, go REQ with new pc.
REQ-029 Redirect in HOLD: held instruction discarded, no o_dec_en, go REQ.
REQ-030 Redirect in IDLE: pc updated only; state follows i_run.
REQ-031 i_run deasserted in REQ/WAIT/HOLD: outstanding transaction completes per REQ-019..021, then IDLE.

Reset
REQ-032 rst=0 SHALL immediately force state IDLE, pc=RESET_PC, drop flag=0, o_mem_req=0, o_mem_addr=0, o_instruction=0, o_pc=0, o_dec_en=0.
REQ-033 Reset mid-transaction: any rvalid for the aborted request arriving after reset release SHALL be ignored (IDLE ignores rvalid).

Verification
REQ-034 Reset release, i_run=1, ack immediate, rvalid 2 cycles later with 32'h00000013 -> o_mem_addr=0, then o_dec_en pulse, o_instruction=32'h00000013, o_pc=0; next o_mem_addr=4.
REQ-035 i_stall=1 for 3 cycles over rvalid -> HOLD, o_dec_en=0 for 3 cycles, single pulse on stall release, o_instruction unchanged.
REQ-036 Redirect to 32'h0000_0102 during WAIT -> returned word dropped, no pulse, next o_mem_addr=32'h0000_0100.
REQ-037 Redirect and rvalid same cycle -> no o_dec_en; next request at redirect target.
REQ-038 Redirect to 32'hFFFF_FFFC, two fetches -> o_pc 32'hFFFF_FFFC then 32'h0000_0000.
REQ-039 rst=0 asserted in WAIT, rvalid after release with i_run=0 -> o_dec_en stays 0, o_mem_req stays 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues one word-aligned fetch at a time, hands the
// returned word to decode with a one-cycle strobe, and absorbs stalls and redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_run,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_instruction,
    output logic        o_dec_en,
    output logic [31:0] o_pc
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        drop;

    logic [31:0] redirect_target;
    logic [31:0] pc_next;
    logic        capture;
    logic        deliver;
    logic        complete;
    logic        start;

    assign redirect_target = {i_redirect_pc[31:2], 2'b00};

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        capture  = 1'b0;
        deliver  = 1'b0;
        complete = 1'b0;
        case (state)
            WAIT: begin
                capture  = i_mem_rvalid && !drop && !i_redirect;
                deliver  = capture && !i_stall;
                complete = i_mem_rvalid && (drop || i_redirect || !i_stall);
            end
            HOLD: begin
                deliver  = !i_redirect && !i_stall;
                complete = i_redirect || !i_stall;
            end
            default: ;
        endcase

        if (i_redirect)
            pc_next = redirect_target;
        else if (deliver)
            pc_next = pc + 32'd4;
        else
            pc_next = pc;

        // A finished transaction (delivered or discarded) only re-arms a fetch while running.
        start = i_run && ((state == IDLE) || complete);
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            drop          <= 1'b0;
            o_mem_req     <= 1'b0;
            o_mem_addr    <= 32'h0000_0000;
            o_instruction <= 32'h0000_0000;
            o_pc          <= 32'h0000_0000;
            o_dec_en      <= 1'b0;
        end else begin
            o_dec_en <= deliver;
            pc       <= pc_next;

            if (start) begin
                o_mem_req  <= 1'b1;
                o_mem_addr <= pc_next;
            end else if (state == REQ && i_mem_ack) begin
                o_mem_req  <= 1'b0;
            end

            if (capture) begin
                o_instruction <= i_mem_rdata;
                o_pc          <= pc;
            end

            case (state)
                IDLE: begin
                    if (i_run)
                        state <= REQ;
                end
                REQ: begin
                    // The request on the bus keeps its address; its response is marked stale instead.
                    if (i_redirect)
                        drop <= 1'b1;
                    if (i_mem_ack)
                        state <= WAIT;
                end
                WAIT: begin
                    if (i_mem_rvalid) begin
                        drop <= 1'b0;
                        if (complete)
                            state <= i_run ? REQ : IDLE;
                        else
                            state <= HOLD;
                    end else if (i_redirect) begin
                        drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (complete)
                        state <= i_run ? REQ : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios, then random traffic checked against a
// transaction-level model through an expected-instruction scoreboard.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_run = 1'b0;
    logic        i_mem_ack = 1'b0;
    logic        i_mem_rvalid = 1'b0;
    logic [31:0] i_mem_rdata = 32'h0;
    logic        i_stall = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic [31:0] o_instruction;
    logic        o_dec_en;
    logic [31:0] o_pc;

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .i_run         (i_run),
        .o_mem_req     (o_mem_req),
        .o_mem_addr    (o_mem_addr),
        .i_mem_ack     (i_mem_ack),
        .i_mem_rvalid  (i_mem_rvalid),
        .i_mem_rdata   (i_mem_rdata),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_instruction (o_instruction),
        .o_dec_en      (o_dec_en),
        .o_pc          (o_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Transaction-level model of the fetch stream.
    logic [31:0] m_pc;
    logic [31:0] req_addr, out_addr, held_addr, held_data;
    bit          req_seen, pend_doom, outst, doomed, held_v;
    int unsigned lat;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic expect_instr(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back(exp_t'{pc: pc, instr: instr});
    endtask

    // Monitor: every decode strobe must match the oldest expected delivery.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (o_dec_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dec_unexpected: got pulse pc=%h instr=%h expected none at %0t",
                             o_pc, o_instruction, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("dec_pc", o_pc, e.pc);
                    check("dec_instr", o_instruction, e.instr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Assumes the DUT is presenting a request; acks it and returns one word a cycle later.
    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] data, input bit deliver);
        check1("fetch_req", o_mem_req, 1'b1);
        check("fetch_addr", o_mem_addr, addr);
        i_mem_ack = 1'b1;
        @(negedge clk);
        i_mem_ack    = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = data;
        if (deliver)
            expect_instr(addr, data);
        @(negedge clk);
        i_mem_rvalid = 1'b0;
    endtask

    // One random cycle: observe request bus, choose inputs, advance the model across the next edge.
    task automatic rand_cycle(input bit quiet);
        logic [31:0] data, tgt;
        bit          redir, stall, ack, rv;

        if (o_mem_req) begin
            if (!req_seen) begin
                check("req_addr", o_mem_addr, m_pc);
                req_seen = 1'b1;
                req_addr = o_mem_addr;
            end else begin
                check("req_addr_hold", o_mem_addr, req_addr);
            end
        end
        if (outst || held_v)
            check1("single_outstanding", o_mem_req, 1'b0);

        if (quiet) begin
            i_run = 1'b0;
            stall = 1'b0;
            redir = 1'b0;
        end else begin
            if ($urandom_range(0, 99) < 6)
                i_run = ~i_run;
            stall = ($urandom_range(0, 99) < 35);
            redir = ($urandom_range(0, 99) < 6);
        end
        tgt  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        ack  = o_mem_req && ($urandom_range(0, 99) < 60);
        rv   = 1'b0;
        if (outst) begin
            if (lat == 0)
                rv = 1'b1;
            else
                lat--;
        end
        data = $urandom;

        i_stall       = stall;
        i_redirect    = redir;
        i_redirect_pc = tgt;
        i_mem_ack     = ack;
        i_mem_rvalid  = rv;
        i_mem_rdata   = data;

        if (held_v) begin
            if (redir) begin
                held_v = 1'b0;
            end else if (!stall) begin
                expect_instr(held_addr, held_data);
                m_pc   = held_addr + 32'd4;
                held_v = 1'b0;
            end
        end else if (outst && rv) begin
            outst = 1'b0;
            if (!(doomed || redir)) begin
                if (stall) begin
                    held_v    = 1'b1;
                    held_addr = out_addr;
                    held_data = data;
                end else begin
                    expect_instr(out_addr, data);
                    m_pc = out_addr + 32'd4;
                end
            end
        end else if (outst && redir) begin
            doomed = 1'b1;
        end

        if (o_mem_req) begin
            if (ack) begin
                outst     = 1'b1;
                out_addr  = req_addr;
                doomed    = pend_doom || redir;
                pend_doom = 1'b0;
                req_seen  = 1'b0;
                lat       = $urandom_range(0, 3);
            end else if (redir) begin
                pend_doom = 1'b1;
            end
        end

        if (redir)
            m_pc = {tgt[31:2], 2'b00};

        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check1("rst_mem_req", o_mem_req, 1'b0);
        check("rst_mem_addr", o_mem_addr, 32'h0);
        check("rst_instr", o_instruction, 32'h0);
        check("rst_pc", o_pc, 32'h0);
        check1("rst_dec_en", o_dec_en, 1'b0);

        // First fetch after reset, rvalid two cycles after ack
        rst   = 1'b1;
        i_run = 1'b1;
        @(negedge clk);
        check1("first_req", o_mem_req, 1'b1);
        check("first_addr", o_mem_addr, 32'h0);
        i_mem_ack = 1'b1;
        @(negedge clk);
        i_mem_ack = 1'b0;
        check1("req_low_after_ack", o_mem_req, 1'b0);
        @(negedge clk);
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h0000_0013;
        expect_instr(32'h0, 32'h0000_0013);
        @(negedge clk);
        i_mem_rvalid = 1'b0;
        check1("second_req", o_mem_req, 1'b1);
        check("second_addr", o_mem_addr, 32'h4);

        // Stall held for three cycles over the returned word
        i_mem_ack = 1'b1;
        @(negedge clk);
        i_mem_ack    = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hDEAD_0001;
        i_stall      = 1'b1;
        @(negedge clk);
        i_mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check1("hold_no_dec", o_dec_en, 1'b0);
            check("hold_instr", o_instruction, 32'hDEAD_0001);
            check("hold_pc", o_pc, 32'h4);
            if (k == 2) begin
                i_stall = 1'b0;
                expect_instr(32'h4, 32'hDEAD_0001);
            end
            @(negedge clk);
        end
        check("after_hold_addr", o_mem_addr, 32'h8);

        // Redirect during WAIT drops the returned word
        i_mem_ack = 1'b1;
        @(negedge clk);
        i_mem_ack     = 1'b0;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0102;
        @(negedge clk);
        i_redirect   = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hBAD0_0001;
        @(negedge clk);
        i_mem_rvalid = 1'b0;
        check1("wait_redir_req", o_mem_req, 1'b1);
        check("wait_redir_addr", o_mem_addr, 32'h0000_0100);

        // Redirect coincident with rvalid
        i_mem_ack = 1'b1;
        @(negedge clk);
        i_mem_ack     = 1'b0;
        i_mem_rvalid  = 1'b1;
        i_mem_rdata   = 32'hBAD0_0002;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0200;
        @(negedge clk);
        i_mem_rvalid = 1'b0;
        i_redirect   = 1'b0;
        check1("rv_redir_req", o_mem_req, 1'b1);
        check("rv_redir_addr", o_mem_addr, 32'h0000_0200);

        // Redirect while a request is unacknowledged, then fetch across the address wrap
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        i_redirect = 1'b0;
        fetch_one(32'h0000_0200, 32'hBAD0_0003, 1'b0);
        fetch_one(32'hFFFF_FFFC, 32'hA5A5_0001, 1'b1);
        fetch_one(32'h0000_0000, 32'hA5A5_0002, 1'b1);

        // Reset in WAIT; the late response must be ignored
        check("pre_rst_addr", o_mem_addr, 32'h4);
        i_mem_ack = 1'b1;
        @(negedge clk);
        i_mem_ack = 1'b0;
        rst       = 1'b0;
        i_run     = 1'b0;
        #1;
        check1("async_rst_req", o_mem_req, 1'b0);
        check("async_rst_pc", o_pc, 32'h0);
        check("async_rst_instr", o_instruction, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hBAD0_0004;
        @(negedge clk);
        i_mem_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check1("post_rst_req", o_mem_req, 1'b0);
            check1("post_rst_dec", o_dec_en, 1'b0);
            @(negedge clk);
        end

        // Redirect while idle only moves the pc
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0043;
        @(negedge clk);
        i_redirect = 1'b0;
        check1("idle_redir_req", o_mem_req, 1'b0);
        i_run = 1'b1;
        @(negedge clk);
        check("idle_redir_addr", o_mem_addr, 32'h0000_0040);

        // Random traffic from a fresh reset
        i_run = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        i_run     = 1'b1;
        m_pc      = 32'h0;
        req_seen  = 1'b0;
        pend_doom = 1'b0;
        outst     = 1'b0;
        doomed    = 1'b0;
        held_v    = 1'b0;
        lat       = 0;
        repeat (3000) rand_cycle(1'b0);
        for (int n = 0; n < 200 && (outst || held_v || o_mem_req); n++)
            rand_cycle(1'b1);
        check1("drain_idle", outst || held_v || o_mem_req, 1'b0);
        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
